dac_fifo: RTL and testbench

//   Bus-writable stereo sample FIFO feeding the DAC control circuit.
//   CPU writes packed {left,right} 16-bit samples through a 2-register I/O window.
//   On each `next` pulse from the DAC it pops one entry onto sample_l/sample_r.

---
 rtl/dac_fifo_pkg.sv | 55 +++++
 rtl/dac_fifo_ram.sv | 39 +++
 rtl/dac_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_dac_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_fifo_pkg.sv
// -----------------------------------------------------------------------------
// dac_fifo_pkg
//   Shared definitions for the DAC sample FIFO: bus register offsets, STATUS
//   bit positions, CTRL command bits, the packed sample-pair type, and a
//   helper that assembles the CTRL/STATUS read word.
//   Configuration macro used by the design: DAC_FIFO_HOLD_LAST_EN
//   (defined: samples hold their last value on underrun; undefined: silence).
// -----------------------------------------------------------------------------
package dac_fifo_pkg;

  // Bus register offsets (single address bit)
  localparam logic ADDR_CTRL = 1'b0;
  localparam logic ADDR_DATA = 1'b1;

  // STATUS read bit positions
  localparam int ST_IEN       = 0;
  localparam int ST_HALF      = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_EMPTY     = 3;
  localparam int ST_UNDERRUN  = 4;
  localparam int ST_LEVEL_LSB = 16;

  // CTRL write command bits
  localparam int CMD_IEN          = 0;
  localparam int CMD_CLR_UNDERRUN = 4;
  localparam int CMD_FLUSH        = 7;

  // One FIFO entry: left channel in the upper half, right in the lower half
  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } sample_pair_t;

  // Assemble the CTRL/STATUS read word. The level is passed zero-extended to
  // 16 bits so the helper is independent of the FIFO depth; unused bits are 0.
  function automatic logic [31:0] pack_status(
    input logic        ien,
    input logic        half,
    input logic        full,
    input logic        empty,
    input logic        underrun,
    input logic [15:0] level
  );
    logic [31:0] word;
    word                          = 32'h0000_0000;
    word[ST_IEN]                  = ien;
    word[ST_HALF]                 = half;
    word[ST_FULL]                 = full;
    word[ST_EMPTY]                = empty;
    word[ST_UNDERRUN]             = underrun;
    word[ST_LEVEL_LSB+15:ST_LEVEL_LSB] = level;
    return word;
  endfunction

endpackage

// File: rtl/dac_fifo_ram.sv
// -----------------------------------------------------------------------------
// dac_fifo_ram
//   2**DEPTH_LOG2 x 32 sample storage. One synchronous write port, one
//   asynchronous read port (the FIFO head is always visible combinationally,
//   so a pop can capture it on the same edge that advances the read pointer).
//   The array has no reset: validity of entries is tracked by the pointers.
// Ports
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address (write pointer)
//   wdata_i  in   write data
//   raddr_i  in   read address (read pointer)
//   rdata_o  out  read data at raddr_i
// -----------------------------------------------------------------------------
module dac_fifo_ram #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [31:0] mem_q [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dac_fifo.sv
// -----------------------------------------------------------------------------
// dac_fifo
//   Bus-writable stereo sample FIFO feeding the DAC. The CPU pushes packed
//   {left,right} words through the DATA register; each single-cycle `next`
//   from the DAC pops one entry onto sample_l/sample_r. A level interrupt
//   (ien & half) tells software when to refill.
//   Configuration macro: DAC_FIFO_HOLD_LAST_EN
//     defined   -> on underrun the sample outputs keep their previous value
//     undefined -> on underrun the sample outputs are forced to 0 (silence)
// Ports
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   stb       in   bus strobe, one access per cycle
//   we        in   1 = write, 0 = read
//   addr      in   0 = CTRL/STATUS, 1 = DATA
//   data_in   in   write data
//   data_out  out  read data (STATUS for addr 0, zero for addr 1)
//   wt        out  bus wait, always 0
//   irq       out  registered level interrupt
//   next      in   DAC request for the next sample pair
//   sample_l  out  current left sample
//   sample_r  out  current right sample
// -----------------------------------------------------------------------------
module dac_fifo
  import dac_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stb,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        wt,
  output logic        irq,
  input  logic        next,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   LEVEL_ZERO = (DEPTH_LOG2+1)'(0);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_HALF = (DEPTH_LOG2+1)'(DEPTH / 2);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO   = (DEPTH_LOG2)'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);

  // State registers and their next-state values
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  ien_q, ien_d;
  logic                  underrun_q, underrun_d;
  logic                  irq_q, irq_d;
  logic [15:0]           sample_l_q, sample_l_d;
  logic [15:0]           sample_r_q, sample_r_d;

  // Decode and flag signals
  logic         data_wr_s;
  logic         ctrl_wr_s;
  logic         flush_s;
  logic         full_s;
  logic         empty_s;
  logic         half_s;
  logic         pop_ok_s;
  logic         push_ok_s;
  logic         starve_s;
  logic         underrun_set_s;
  logic         underrun_clr_s;
  sample_pair_t head_s;
  logic [31:0]  status_s;

  // Bus decode and occupancy flags, all taken from the pre-edge state
  always_comb begin
    data_wr_s = stb & we & (addr == ADDR_DATA);
    ctrl_wr_s = stb & we & (addr == ADDR_CTRL);
    flush_s   = ctrl_wr_s & data_in[CMD_FLUSH];

    full_s  = (level_q == LEVEL_FULL);
    empty_s = (level_q == LEVEL_ZERO);
    half_s  = (level_q <= LEVEL_HALF);

    // A flush overrides the pop: the DAC request is served as a starvation.
    pop_ok_s = next & ~empty_s & ~flush_s;
    starve_s = next & (empty_s | flush_s);

    // A pop in the same cycle frees a slot, so a push at full still lands.
    push_ok_s = data_wr_s & ~flush_s & (~full_s | pop_ok_s);

    // The underrun flag only records a request against an already-empty
    // FIFO; a flush-induced starvation of a non-empty FIFO is not flagged.
    underrun_set_s = next & empty_s;
    underrun_clr_s = ctrl_wr_s & data_in[CMD_CLR_UNDERRUN];
  end

  dac_fifo_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .we_i    (push_ok_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_s)
  );

  // Next-state computation for pointers, level, flags and sample outputs
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ien_d      = ien_q;
    underrun_d = underrun_q;
    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;

    if (flush_s) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      level_d  = LEVEL_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_d = level_q + LEVEL_ONE;
        2'b01:   level_d = level_q - LEVEL_ONE;
        default: level_d = level_q;
      endcase
    end

    if (ctrl_wr_s) begin
      ien_d = data_in[CMD_IEN];
    end else begin
      ien_d = ien_q;
    end

    // Setting wins over a simultaneous software clear.
    if (underrun_set_s) begin
      underrun_d = 1'b1;
    end else if (underrun_clr_s) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end

    if (pop_ok_s) begin
      sample_l_d = head_s.left;
      sample_r_d = head_s.right;
    end else if (starve_s) begin
`ifdef DAC_FIFO_HOLD_LAST_EN
      sample_l_d = sample_l_q;
      sample_r_d = sample_r_q;
`else
      sample_l_d = 16'h0000;
      sample_r_d = 16'h0000;
`endif
    end else begin
      sample_l_d = sample_l_q;
      sample_r_d = sample_r_q;
    end

    // Interrupt follows the registered state, so it lags a level change by one cycle.
    irq_d = ien_q & half_s;
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      level_q    <= LEVEL_ZERO;
      ien_q      <= 1'b0;
      underrun_q <= 1'b0;
      irq_q      <= 1'b0;
      sample_l_q <= 16'h0000;
      sample_r_q <= 16'h0000;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ien_q      <= ien_d;
      underrun_q <= underrun_d;
      irq_q      <= irq_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
    end
  end

  // Read mux: STATUS at the CTRL offset, zero at the DATA offset
  always_comb begin
    status_s = pack_status(ien_q, half_s, full_s, empty_s, underrun_q, 16'(level_q));
    if (addr == ADDR_CTRL) begin
      data_out = status_s;
    end else begin
      data_out = 32'h0000_0000;
    end
  end

  assign wt       = 1'b0;
  assign irq      = irq_q;
  assign sample_l = sample_l_q;
  assign sample_r = sample_r_q;

endmodule

// File: tb/tb_dac_fifo.sv
// -----------------------------------------------------------------------------
// tb_dac_fifo
//   Self-checking bench for dac_fifo. A queue-based reference model tracks
//   the FIFO contents, flags, interrupt and sample outputs from the bus and
//   DAC rules; directed scenarios plus a randomized run compare the DUT
//   against it (and against literal values where they are fixed).
// -----------------------------------------------------------------------------
module tb_dac_fifo;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic        addr = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        wt;
  logic        irq;
  logic        next = 1'b0;
  logic [15:0] sample_l;
  logic [15:0] sample_r;

  int checks = 0;
  int errors = 0;

  dac_fifo dut (
    .clk      (clk),
    .reset    (reset),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .wt       (wt),
    .irq      (irq),
    .next     (next),
    .sample_l (sample_l),
    .sample_r (sample_r)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] mq[$];
  bit          m_ien, m_und, m_irq;
  logic [15:0] m_sl, m_sr;

  function automatic void model_reset();
    mq.delete();
    m_ien = 1'b0; m_und = 1'b0; m_irq = 1'b0;
    m_sl = 16'h0; m_sr = 16'h0;
  endfunction

  function automatic logic [31:0] m_status();
    int lvl;
    lvl = mq.size();
    return {9'b0, 7'(lvl), 11'b0, m_und, (lvl == 0), (lvl == DEPTH),
            (lvl <= DEPTH / 2), m_ien};
  endfunction

  function automatic void model_step(input logic s, input logic w, input logic a,
                                     input logic [31:0] d, input logic n);
    bit data_wr, ctrl_wr, flush, was_empty, was_half;
    logic [31:0] head;
    data_wr   = s & w & a;
    ctrl_wr   = s & w & ~a;
    flush     = ctrl_wr & d[7];
    was_empty = (mq.size() == 0);
    was_half  = (mq.size() <= DEPTH / 2);
    if (n && (was_empty || flush)) begin
`ifndef DAC_FIFO_HOLD_LAST_EN
      m_sl = 16'h0; m_sr = 16'h0;
`endif
    end else if (n) begin
      head = mq.pop_front();
      m_sl = head[31:16]; m_sr = head[15:0];
    end
    if (flush) mq.delete();
    else if (data_wr && mq.size() < DEPTH) mq.push_back(d);
    m_irq = m_ien & was_half;
    if (ctrl_wr) m_ien = d[0];
    if (n && was_empty) m_und = 1'b1;
    else if (ctrl_wr && d[4]) m_und = 1'b0;
  endfunction

  // ---------------- drivers ----------------
  task automatic step(input logic s, input logic w, input logic a,
                      input logic [31:0] d, input logic n);
    stb = s; we = w; addr = a; data_in = d; next = n;
    @(posedge clk);
    model_step(s, w, a, d, n);
    #1;
    stb = 1'b0; we = 1'b0; addr = 1'b0; data_in = 32'h0; next = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (data_out !== 32'h0000_000A) begin errors++; $display("FAIL reset_status got %h exp %h", data_out, 32'h0000_000A); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    checks++; if ({sample_l, sample_r} !== 32'h0) begin errors++; $display("FAIL reset_samples got %h exp 0", {sample_l, sample_r}); end
    checks++; if (wt !== 1'b0) begin errors++; $display("FAIL reset_wt got %b exp 0", wt); end
  endtask

  task automatic test_basic();
    do_reset();
    step(1'b1, 1'b1, 1'b1, 32'h0FF0AA55, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0);
    checks++; if (data_out[22:16] !== 7'd2) begin errors++; $display("FAIL basic_level2 got %0d exp 2", data_out[22:16]); end
    // DATA read returns zero with no side effect
    stb = 1'b1; we = 1'b0; addr = 1'b1; #1;
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL data_read got %h exp 0", data_out); end
    @(posedge clk); model_step(1'b1, 1'b0, 1'b1, 32'h0, 1'b0); #1;
    stb = 1'b0; addr = 1'b0; #1;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if ({sample_l, sample_r} !== 32'h0FF0AA55) begin errors++; $display("FAIL basic_pop1 got %h exp %h", {sample_l, sample_r}, 32'h0FF0AA55); end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if ({sample_l, sample_r} !== 32'h12345678) begin errors++; $display("FAIL basic_pop2 got %h exp %h", {sample_l, sample_r}, 32'h12345678); end
    checks++; if (data_out !== m_status()) begin errors++; $display("FAIL basic_status got %h exp %h", data_out, m_status()); end
  endtask

  task automatic test_full();
    bit seen_drop;
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b1, 32'h0100_0000 + 32'(i), 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
    checks++; if (data_out[2] !== 1'b1 || data_out[22:16] !== 7'd64) begin errors++; $display("FAIL full_flag got %h exp full level 64", data_out); end
    step(1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1);
    checks++; if (data_out[22:16] !== 7'd64) begin errors++; $display("FAIL full_pushpop_level got %0d exp 64", data_out[22:16]); end
    checks++; if ({sample_l, sample_r} !== 32'h01000000) begin errors++; $display("FAIL full_pushpop_sample got %h exp 01000000", {sample_l, sample_r}); end
    seen_drop = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      if ({sample_l, sample_r} === 32'hDEADBEEF) seen_drop = 1'b1;
      checks++; if ({sample_l, sample_r} !== {m_sl, m_sr}) begin errors++; $display("FAIL full_drain[%0d] got %h exp %h", i, {sample_l, sample_r}, {m_sl, m_sr}); end
    end
    checks++; if (seen_drop) begin errors++; $display("FAIL full_dropped_word got output exp never"); end
    checks++; if ({sample_l, sample_r} !== 32'hCAFEF00D || data_out !== 32'h0000_000A) begin errors++; $display("FAIL full_last got %h status %h exp cafef00d status 0000000a", {sample_l, sample_r}, data_out); end
  endtask

  task automatic test_irq();
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b1, $urandom, 1'b0);
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL irq_fill[%0d] got %b exp %b", i, irq, m_irq); end
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (data_out[22:16] !== 7'd32 || irq !== 1'b0) begin errors++; $display("FAIL irq_at32 level %0d irq %b exp 32 0", data_out[22:16], irq); end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq); end
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++; if (irq !== m_irq) begin errors++; $display("FAIL irq_ien0_lag got %b exp %b", irq, m_irq); end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b exp 0", irq); end
  endtask

  task automatic test_underrun();
    logic [31:0] exp_s;
    do_reset();
    step(1'b1, 1'b1, 1'b1, 32'h11112222, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
`ifdef DAC_FIFO_HOLD_LAST_EN
    exp_s = 32'h11112222;
`else
    exp_s = 32'h0;
`endif
    checks++; if (data_out[4] !== 1'b1) begin errors++; $display("FAIL underrun_set got %b exp 1", data_out[4]); end
    checks++; if ({sample_l, sample_r} !== exp_s) begin errors++; $display("FAIL underrun_sample got %h exp %h", {sample_l, sample_r}, exp_s); end
    step(1'b1, 1'b1, 1'b0, 32'h10, 1'b0);
    checks++; if (data_out[4] !== 1'b0) begin errors++; $display("FAIL underrun_clear got %b exp 0", data_out[4]); end
    step(1'b1, 1'b1, 1'b0, 32'h10, 1'b1);
    checks++; if (data_out[4] !== 1'b1) begin errors++; $display("FAIL underrun_set_wins got %b exp 1", data_out[4]); end
    step(1'b1, 1'b1, 1'b0, 32'h10, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h33334444, 1'b1);
    checks++; if (data_out !== m_status() || data_out[22:16] !== 7'd1 || data_out[4] !== 1'b1) begin errors++; $display("FAIL underrun_pushpop_empty got %h exp %h", data_out, m_status()); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 32'hA000_0000 + 32'(i), 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h80, 1'b1);
    checks++; if (data_out[22:16] !== 7'd0 || data_out[4] !== 1'b0) begin errors++; $display("FAIL flush_next got %h exp level 0 underrun 0", data_out); end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 32'h5A5A_0001 + 32'(i), 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (data_out[22:16] !== 7'd5 || {sample_l, sample_r} !== 32'h5A5A0001) begin errors++; $display("FAIL flush_refill level %0d sample %h exp 5 5a5a0001", data_out[22:16], {sample_l, sample_r}); end
    do_reset();
    checks++; if (data_out !== 32'h0000_000A || {sample_l, sample_r} !== 32'h0) begin errors++; $display("FAIL midstream_reset status %h sample %h exp 0000000a 0", data_out, {sample_l, sample_r}); end
  endtask

  task automatic test_random();
    logic s, w, a, n;
    logic [31:0] d;
    int r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      s = 1'b0; w = 1'b0; a = 1'b0; d = $urandom;
      if (r < 50) begin s = 1'b1; w = 1'b1; a = 1'b1; end
      else if (r < 58) begin s = 1'b1; w = 1'b1; a = 1'b0; d[7] = ($urandom_range(0, 9) == 0); end
      else if (r < 63) begin s = 1'b1; w = 1'b0; a = $urandom_range(0, 1); end
      n = ($urandom_range(0, 99) < 42);
      if (s && w && !a && d[7]) n = 1'b0;
      step(s, w, a, d, n);
      checks++; if (data_out !== m_status()) begin errors++; $display("FAIL rand_status[%0d] got %h exp %h", i, data_out, m_status()); end
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq[%0d] got %b exp %b", i, irq, m_irq); end
      checks++; if ({sample_l, sample_r} !== {m_sl, m_sr}) begin errors++; $display("FAIL rand_sample[%0d] got %h exp %h", i, {sample_l, sample_r}, {m_sl, m_sr}); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_full();
    test_irq();
    test_underrun();
    test_flush_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
